// File: rtl/controle_rolhas_if.sv
// controle_rolhas_if
//   Bundles the cork-magazine controller's pulse inputs and status outputs.
//   master: the side that issues consumo/carga pulses and reads status
//           (production FSM, reservoir sensor, display, test bench).
//   slave : controle_rolhas itself.
//   Signals:
//     consumo, carga            one-cycle pulses into the controller
//     estoque_dezenas/unidades  stock as two BCD digits
//     pedir_carga               reservoir valve request
//     rolha_ok                  stock is non-zero, sealing allowed
//     falta, alarme             sticky shortage flag and alarm output
//     estado                    00 NORMAL, 01 CARREGANDO, 10 FALHA
interface controle_rolhas_if;
  logic       consumo;
  logic       carga;
  logic [3:0] estoque_dezenas;
  logic [3:0] estoque_unidades;
  logic       pedir_carga;
  logic       rolha_ok;
  logic       falta;
  logic       alarme;
  logic [1:0] estado;

  modport master (
    output consumo, carga,
    input  estoque_dezenas, estoque_unidades, pedir_carga, rolha_ok,
           falta, alarme, estado
  );

  modport slave (
    input  consumo, carga,
    output estoque_dezenas, estoque_unidades, pedir_carga, rolha_ok,
           falta, alarme, estado
  );
endinterface

// File: rtl/controle_rolhas.sv
// controle_rolhas
//   Cork-magazine stock controller. Keeps the magazine stock as two BCD
//   digits, decrements on consumo, increments on carga, and opens the
//   reservoir feed (pedir_carga) when stock drops to LIMIAR_MIN until it
//   reaches CARGA_MAX.
//   Optional build macro: CONTROLE_ROLHAS_TIMEOUT_EN adds the refill timeout
//   timer and the FALHA state. Without it, CARREGANDO waits forever for
//   carga and alarme is just falta.
//   Ports:
//     clock  rising-edge system clock
//     reset  asynchronous, active-high; clears all state
//     bus    controle_rolhas_if.slave (pulses in, stock/status out)
//
//   state      | meaning
//   NORMAL     | stock above the low-water mark, feed closed
//   CARREGANDO | refilling, feed open until stock reaches CARGA_MAX
//   FALHA      | refill timed out; feed closed, waits for a manual carga
module controle_rolhas #(
  parameter int LIMIAR_MIN    = 5,
  parameter int CARGA_MAX     = 99,
  parameter int TIMEOUT_CARGA = 1000
) (
  input  logic               clock,
  input  logic               reset,
  controle_rolhas_if.slave   bus
);

  typedef enum logic [1:0] {
    NORMAL     = 2'b00,
    CARREGANDO = 2'b01,
    FALHA      = 2'b10
  } estado_t;

  localparam logic [6:0] LIM7 = 7'(LIMIAR_MIN);
  localparam logic [6:0] MAX7 = 7'(CARGA_MAX);

  estado_t    st_q, st_n;
  logic [3:0] dez_q, uni_q, dez_n, uni_n;
  logic       falta_q, falta_n;
  logic       pedir_q, rolha_q, alarme_q, alarme_n;
  logic [6:0] stock_bin;
  logic       vazio, cheio, baixo, inc, dec;

  // Binary view of the registered stock, only used for threshold compares.
  assign stock_bin = ({3'b000, dez_q} * 7'd10) + {3'b000, uni_q};
  assign vazio     = (dez_q == 4'd0) && (uni_q == 4'd0);
  assign cheio     = (stock_bin == MAX7);
  assign baixo     = (stock_bin <= LIM7);

  // Simultaneous consumo and carga cancel out.
  assign inc = bus.carga & ~bus.consumo & ~cheio;
  assign dec = bus.consumo & ~bus.carga & ~vazio;

`ifdef CONTROLE_ROLHAS_TIMEOUT_EN
  localparam int            TW     = $clog2(TIMEOUT_CARGA + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CARGA - 1);
  logic [TW-1:0] tmr_q, tmr_n;
`endif

  always_comb begin
    dez_n = dez_q;
    uni_n = uni_q;
    if (inc) begin
      if (uni_q == 4'd9) begin
        uni_n = 4'd0;
        dez_n = dez_q + 4'd1;
      end else begin
        uni_n = uni_q + 4'd1;
      end
    end else if (dec) begin
      if (uni_q == 4'd0) begin
        uni_n = 4'd9;
        dez_n = dez_q - 4'd1;
      end else begin
        uni_n = uni_q - 4'd1;
      end
    end

    // carga wins over a shortage detected on the same edge.
    falta_n = falta_q;
    if (bus.carga)
      falta_n = 1'b0;
    else if (bus.consumo && vazio)
      falta_n = 1'b1;

    // Transitions look at the pre-update stock, so they lag the stock by one edge.
    st_n = st_q;
    case (st_q)
      NORMAL: if (baixo) st_n = CARREGANDO;
      CARREGANDO: begin
        if (cheio) st_n = NORMAL;
`ifdef CONTROLE_ROLHAS_TIMEOUT_EN
        else if ((tmr_q == T_LAST) && !bus.carga) st_n = FALHA;
`endif
      end
      FALHA: if (bus.carga) st_n = CARREGANDO;
      default: st_n = NORMAL;
    endcase

`ifdef CONTROLE_ROLHAS_TIMEOUT_EN
    // Counts idle refill cycles; any entry, exit or carga restarts it.
    tmr_n = '0;
    if ((st_q == CARREGANDO) && (st_n == CARREGANDO) && !bus.carga)
      tmr_n = tmr_q + 1'b1;
    alarme_n = falta_n | (st_n == FALHA);
`else
    alarme_n = falta_n;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q     <= NORMAL;
      dez_q    <= 4'd0;
      uni_q    <= 4'd0;
      falta_q  <= 1'b0;
      pedir_q  <= 1'b0;
      rolha_q  <= 1'b0;
      alarme_q <= 1'b0;
`ifdef CONTROLE_ROLHAS_TIMEOUT_EN
      tmr_q    <= '0;
`endif
    end else begin
      st_q     <= st_n;
      dez_q    <= dez_n;
      uni_q    <= uni_n;
      falta_q  <= falta_n;
      pedir_q  <= (st_n == CARREGANDO);
      rolha_q  <= (dez_n != 4'd0) || (uni_n != 4'd0);
      alarme_q <= alarme_n;
`ifdef CONTROLE_ROLHAS_TIMEOUT_EN
      tmr_q    <= tmr_n;
`endif
    end
  end

  assign bus.estoque_dezenas  = dez_q;
  assign bus.estoque_unidades = uni_q;
  assign bus.pedir_carga      = pedir_q;
  assign bus.rolha_ok         = rolha_q;
  assign bus.falta            = falta_q;
  assign bus.alarme           = alarme_q;
  assign bus.estado           = st_q;

endmodule

// File: tb/tb_controle_rolhas.sv
// tb_controle_rolhas
//   Drives controle_rolhas with directed and random consumo/carga pulses.
//   A behavioural model (integer stock, integer state code, idle-cycle count)
//   predicts the outputs after each edge; predictions are queued and a
//   monitor compares them one edge later.
module tb_controle_rolhas;
  localparam int LIM = 5;
  localparam int MAX = 99;
  localparam int TO  = 10;
`ifdef CONTROLE_ROLHAS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  controle_rolhas_if bus();

  controle_rolhas #(
    .LIMIAR_MIN(LIM),
    .CARGA_MAX(MAX),
    .TIMEOUT_CARGA(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] dez;
    logic [3:0] uni;
    logic       pedir;
    logic       ok;
    logic       falta;
    logic       alarme;
    logic [1:0] estado;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: 0 NORMAL, 1 CARREGANDO, 2 FALHA.
  int m_stock, m_st, m_idle;
  bit m_falta;

  function automatic void model_reset();
    m_stock = 0;
    m_st    = 0;
    m_idle  = 0;
    m_falta = 1'b0;
  endfunction

  function automatic void model_step(bit c, bit g);
    int old = m_stock;
    if (c && !g) begin
      if (m_stock == 0) m_falta = 1'b1;
      else m_stock = m_stock - 1;
    end else if (g && !c && m_stock < MAX) begin
      m_stock = m_stock + 1;
    end
    if (g) m_falta = 1'b0;
    case (m_st)
      0: if (old <= LIM) begin m_st = 1; m_idle = 0; end
      1: begin
        if (old == MAX) m_st = 0;
        else if (g) m_idle = 0;
        else if (TO_EN && m_idle == TO - 1) begin m_st = 2; m_idle = 0; end
        else m_idle = m_idle + 1;
      end
      default: if (g) begin m_st = 1; m_idle = 0; end
    endcase
  endfunction

  function automatic exp_t expected();
    exp_t e;
    e.dez    = 4'(m_stock / 10);
    e.uni    = 4'(m_stock % 10);
    e.pedir  = (m_st == 1);
    e.ok     = (m_stock != 0);
    e.falta  = m_falta;
    e.alarme = m_falta || (m_st == 2);
    e.estado = 2'(m_st);
    return e;
  endfunction

  task automatic check(string nome, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d (model stock %0d)",
               nome, $time, act, exp, m_stock);
    end
  endtask

  task automatic compare_all(string tag, exp_t e);
    check({tag, " dezenas"},  8'(bus.estoque_dezenas),  8'(e.dez));
    check({tag, " unidades"}, 8'(bus.estoque_unidades), 8'(e.uni));
    check({tag, " pedir"},    8'(bus.pedir_carga),      8'(e.pedir));
    check({tag, " rolha_ok"}, 8'(bus.rolha_ok),         8'(e.ok));
    check({tag, " falta"},    8'(bus.falta),            8'(e.falta));
    check({tag, " alarme"},   8'(bus.alarme),           8'(e.alarme));
    check({tag, " estado"},   8'(bus.estado),           8'(e.estado));
  endtask

  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      compare_all("ciclo", mon_e);
    end
  end

  task automatic ciclo(bit c, bit g);
    @(negedge clock);
    bus.consumo = c;
    bus.carga   = g;
    model_step(c, g);
    sb.push_back(expected());
  endtask

  task automatic aleatorio(int n);
    for (int i = 0; i < n; i++)
      ciclo($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 45);
  endtask

  initial begin
    bus.consumo = 1'b0;
    bus.carga   = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    compare_all("reset", expected());
    reset = 1'b0;

    // Fill from 00 to 99; refill ends one edge after reaching CARGA_MAX.
    repeat (99) ciclo(1'b0, 1'b1);
    repeat (3) ciclo(1'b0, 1'b0);
    // Drain to the low-water mark.
    repeat (94) ciclo(1'b1, 1'b0);
    repeat (3) ciclo(1'b0, 1'b0);
    // Climb to 37, then a simultaneous consumo and carga.
    while (m_stock < 37) ciclo(1'b0, 1'b1);
    ciclo(1'b1, 1'b1);
    repeat (3) ciclo(1'b0, 1'b0);
    // Empty the magazine and keep consuming to raise falta.
    while (m_stock > 0) ciclo(1'b1, 1'b0);
    repeat (2) ciclo(1'b1, 1'b0);
    ciclo(1'b0, 1'b1);
    // Idle refill long enough to time out when the timer is built.
    repeat (TO + 5) ciclo(1'b0, 1'b0);
    ciclo(1'b0, 1'b1);
    repeat (3) ciclo(1'b0, 1'b0);

    aleatorio(400);

    // Reset during a refill at stock 42 clears outputs without a clock edge.
    @(negedge clock);
    bus.consumo = 1'b0;
    bus.carga   = 1'b0;
    reset = 1'b1;
    model_reset();
    #1 compare_all("reset2", expected());
    @(negedge clock);
    reset = 1'b0;
    repeat (42) ciclo(1'b0, 1'b1);
    @(posedge clock);
    #3;
    compare_all("pre_reset42", expected());
    reset = 1'b1;
    model_reset();
    #1 compare_all("async_reset42", expected());
    @(negedge clock);
    bus.carga = 1'b0;
    reset = 1'b0;

    aleatorio(150);

    @(negedge clock);
    bus.consumo = 1'b0;
    bus.carga   = 1'b0;
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d predictions never compared, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded, expected finish before 200000", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/controle_rolhas.md
# controle_rolhas

Cork-magazine stock controller for the bottling line. Tracks the number of corks in the sealing-station magazine as a two-digit BCD value, decrements on every sealing pulse from the main production FSM, and requests refills from the reservoir when stock falls to a low-water mark. Sits directly downstream of the main FSM's VE output and upstream of the display multiplexer and the ALARME output. Its rolha_ok output gates the sealing step.

## Interface

Parameters:
- LIMIAR_MIN, default 5: low-water mark. Refill is requested when stock ≤ LIMIAR_MIN.
- CARGA_MAX, default 99: magazine capacity. A refill ends when stock reaches it.
- TIMEOUT_CARGA, default 1000: maximum number of cycles in CARREGANDO without a carga pulse.
- Legality: 0 ≤ LIMIAR_MIN < CARGA_MAX ≤ 99; TIMEOUT_CARGA ≥ 2.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- consumo  in  1  one-cycle pulse; one cork was used (the VE pulse after level_to_pulse).
- carga  in  1  one-cycle pulse; one cork entered from the reservoir (IR sensor pulse).
- estoque_dezenas  out  4  stock, tens digit, BCD.
- estoque_unidades  out  4  stock, units digit, BCD.
- pedir_carga  out  1  reservoir feed request (valve open).
- rolha_ok  out  1  stock ≠ 0; the main FSM may seal.
- falta  out  1  sticky flag; a consumo arrived while stock was 0.
- alarme  out  1  falta OR (state == FALHA).
- estado  out  2  current state: 00 NORMAL, 01 CARREGANDO, 10 FALHA.

## Operation

Stock:
- Held as two BCD digits and updated directly in BCD, with carry and borrow between digits. Units 9→0 with tens+1; units 0→9 with tens−1.
- Per edge, the net update depends on the inputs:
  - consumo only: −1.
  - carga only: +1.
  - consumo and carga together: no change.
  - neither: no change.
- Saturation: consumo at 00 leaves stock at 00 and sets falta. carga at CARGA_MAX leaves stock unchanged.
- falta clears on any edge with carga=1, or on reset.

State machine (next state is computed from the registered, pre-update stock):
- NORMAL → CARREGANDO when stock ≤ LIMIAR_MIN.
- CARREGANDO:
  - → NORMAL when stock == CARGA_MAX.
  - → FALHA when the timer == TIMEOUT_CARGA−1 and carga=0.
  - Otherwise stays.
- FALHA → CARREGANDO on carga=1 (that carga is also counted). Otherwise stays.
- FALHA does not clear by itself; it only leaves on carga or reset.

Timeout timer:
- Width $clog2(TIMEOUT_CARGA+1).
- Cleared on entry to CARREGANDO and on any carga.
- Increments each CARREGANDO cycle with carga=0.
- Held at 0 in all other states.

Outputs:
- pedir_carga = (state == CARREGANDO). It is 0 in FALHA: the operator loads manually.
- rolha_ok and alarme are decoded only from registered state, so they are glitch-free.

## Timing

- Reset values: state NORMAL; stock 00; timer 0; falta 0. Hence pedir_carga 0, rolha_ok 0, alarme 0, estado 00.
- The first edge after reset is taken with stock 00 ≤ LIMIAR_MIN, so the block enters CARREGANDO and pedir_carga rises one cycle after reset is released.
- Stock latency: the update is visible on the outputs on the edge where consumo/carga is sampled.
- State latency: the state reacts one edge later than the stock. Example: consumo takes stock 06→05 at edge k; estado becomes CARREGANDO at edge k+1.
- Timeout: with no carga, FALHA is entered exactly TIMEOUT_CARGA cycles after entering CARREGANDO.
- Reset asserted mid-refill or in FALHA clears everything immediately, without waiting for a clock edge.
- Inputs are assumed to be synchronous single-cycle pulses. A multi-cycle level counts once per cycle.

## Configuration

- CONTROLE_ROLHAS_TIMEOUT_EN defined: the timeout timer and the FALHA state exist as described above.
- Not defined:
  - The timer is not built.
  - CARREGANDO waits indefinitely for carga.
  - estado never reads 10.
  - alarme = falta.
- Ports are identical in both builds.

## Test plan

- Reset release, then 99 carga pulses: estado goes 00→01 on the first edge, stock counts 00→99 with correct BCD carries (09→10, 19→20), and estado returns to 00 one edge after stock reaches 99.
- From 99 in NORMAL, 94 consumo pulses: stock reaches 05, estado becomes 01 one edge later, and pedir_carga=1.
- consumo and carga on the same edge at stock 37: stock stays 37 and the timer clears.
- consumo at stock 00: stock stays 00, rolha_ok=0, falta=1, alarme=1. The next carga gives stock 01 and falta=0.
- With TIMEOUT_EN and TIMEOUT_CARGA=10, enter CARREGANDO and apply no carga: estado=10, alarme=1, pedir_carga=0 after exactly 10 cycles. One carga then gives estado=01 and stock +1. Without the macro, the block stays at 01 indefinitely.
- Assert reset mid-refill at stock 42: all outputs go to their reset values immediately, before the next clock edge.
